// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int W     = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(op_e o);
    return o[0];
  endfunction

  function automatic logic op_is_div(op_e o);
    return o[1];
  endfunction
endpackage

// File: rtl/muldiv_unit_neg32.sv
// Combinational 32-bit two's-complement negate.
module neg32
  import muldiv_pkg::*;
(
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = ~a + W'(1);
endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide owning HI/LO: 32 magnitude steps then one
// sign-fix cycle, fixed 33-cycle latency.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);
  state_e             state_q, state_d;
  logic               div_q, div_d;
  logic               sgn_q, sgn_d;
  logic               asgn_q, asgn_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, a_raw_q, a_raw_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [W-1:0]       hi_q, hi_d, lo_q, lo_d;

  logic [W-1:0] a_neg, b_neg, lo_neg, hi_neg;

  neg32 u_neg_a  (.a(A),              .y(a_neg));
  neg32 u_neg_b  (.a(B),              .y(b_neg));
  neg32 u_neg_lo (.a(acc_q[W-1:0]),   .y(lo_neg));
  neg32 u_neg_hi (.a(acc_q[2*W-1:W]), .y(hi_neg));

  // Multiply step: add multiplicand into the upper half, shift the whole
  // accumulator right; multiplier bits are consumed LSB-first from b_q.
  logic [W:0]   msum;
  // Divide step: remainder in the upper half, quotient bits enter the lower half.
  logic [W:0]   rem_sh;
  logic [W+1:0] diff;

  assign msum   = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign rem_sh = {acc_q[2*W-1:W], a_q[W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, b_q};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    asgn_d  = asgn_q;
    a_d     = a_q;
    b_d     = b_q;
    a_raw_d = a_raw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          div_d   = op_is_div(op_e'(op));
          sgn_d   = op_is_signed(op_e'(op)) & (A[W-1] ^ B[W-1]);
          asgn_d  = op_is_signed(op_e'(op)) & A[W-1];
          a_d     = (op_is_signed(op_e'(op)) && A[W-1]) ? a_neg : A;
          b_d     = (op_is_signed(op_e'(op)) && B[W-1]) ? b_neg : B;
          a_raw_d = A;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (div_q) begin
          acc_d = diff[W+1] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                            : {diff[W-1:0],   acc_q[W-2:0], 1'b1};
          a_d   = a_q << 1;
        end else begin
          acc_d = {msum, acc_q[W-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q && b_q == '0) begin
          lo_d = '1;
          hi_d = a_raw_q;
        end else if (div_q) begin
          lo_d = sgn_q  ? lo_neg : acc_q[W-1:0];
          hi_d = asgn_q ? hi_neg : acc_q[2*W-1:W];
        end else if (sgn_q) begin
          lo_d = lo_neg;
          hi_d = (acc_q[W-1:0] == '0) ? hi_neg : ~acc_q[2*W-1:W];
        end else begin
          lo_d = acc_q[W-1:0];
          hi_d = acc_q[2*W-1:W];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      asgn_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      asgn_q  <= asgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_raw_q <= a_raw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32×32 multiply/divide unit owning the HI/LO register pair for the single-cycle/multi-cycle CPU datapath. It sits directly upstream of the execute-stage result muxes (MUX32_2_1 instances selecting ALU result vs. HI or LO for MFHI/MFLO writeback). It accepts one operation per start pulse, raises busy for the controller to stall on, and updates HI/LO atomically on completion.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  input  32  multiplicand / dividend (rs)
- B  input  32  multiplier / divisor (rt)
- hi_we  input  1  MTHI: HI <= wdata (IDLE only)
- lo_we  input  1  MTLO: LO <= wdata (IDLE only)
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse, HI/LO just updated
- HI  output  32  HI register (remainder / product high)
- LO  output  32  LO register (quotient / product low)

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 → latch op, A, B; for signed ops store |A|, |B| and result signs; clear 64-bit accumulator; count=0; → CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes; count increments; after 32nd step → FIX.
- FIX: apply sign correction (MULT: negate 64-bit product if sign(A)^sign(B); DIV: negate quotient if sign(A)^sign(B), negate remainder if sign(A)); write HI/LO; → IDLE.
- Divide by zero (B==0, DIVU or DIV): LO = 32'hFFFF_FFFF, HI = A (original, unsigned bits); no sign correction.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0 (natural wrap, no trap).
- start while busy: ignored. hi_we/lo_we while busy: ignored.
- start and hi_we/lo_we same IDLE cycle: write applied at that edge, operation launched; completion overwrites both HI and LO.
- HI/LO change only on FIX edge, hi_we/lo_we edge, or reset.

## Timing
- Reset: state IDLE, busy=0, done=0, HI=0, LO=0, counters/operand latches 0. Reset mid-operation aborts immediately; HI/LO cleared.
- start sampled at edge E0 → busy=1 after E0.
- CALC occupies edges E1..E32; FIX at E33.
- After E33: HI/LO valid, done=1 for exactly one cycle, busy=0; new start accepted in that same cycle (sampled at E34).
- Fixed latency: 33 cycles start-to-result, regardless of op or operand values (no early termination).
- busy and done are registered outputs; no combinational path from inputs to outputs.

## Structure
- Shared package muldiv_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state enum, width constant 32, iteration count 32.
- One sub-module: neg32 (combinational two's-complement negate, used for magnitude extraction and sign fix); 64-bit negate built from two neg32 plus carry or inline.
- Single FSM + datapath in muldiv_unit; no memories.

## Test plan
- MULTU A=FFFFFFFF B=FFFFFFFF → after 33 cycles HI=FFFFFFFE LO=00000001, done pulse 1 cycle, busy high exactly 33 cycles.
- MULT A=FFFFFFFD (−3) B=00000005 → HI=FFFFFFFF LO=FFFFFFF1; DIVU A=00000064 B=00000007 → LO=0000000E HI=00000002.
- DIV A=FFFFFFF9 (−7) B=00000002 → LO=FFFFFFFD HI=FFFFFFFF; DIV A=80000000 B=FFFFFFFF → LO=80000000 HI=00000000.
- DIVU A=00001234 B=00000000 → LO=FFFFFFFF HI=00001234; same with DIV and A=FFFFFFF0 → LO=FFFFFFFF HI=FFFFFFF0.
- start pulsed at cycle 5 of a running op with different operands, and hi_we=1 mid-op → ignored; result matches first op; after done, MTLO wdata=CAFEBABE → LO=CAFEBABE next cycle.
- rst asserted asynchronously at CALC cycle 10 → busy=0, done=0, HI=LO=0 immediately; after release, MULTU 3×4 → LO=0000000C HI=0 at normal latency; back-to-back start in done cycle accepted.
